// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the Wishbone port arbiter: FSM encoding,
// CTI codes, default FIFO channel-select width.
package wb_port_arbiter_pkg;

  localparam int unsigned DEF_SELW         = 3;
  localparam int unsigned FIXED_PRIO_FIRST = 4;
  localparam int unsigned FIXED_PRIO_LEN   = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // A beat is the last of its burst for classic cycles and end-of-burst.
  function automatic logic cti_is_last(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Round-robin first-one finder: lowest-distance set bit above i_ptr,
// wrapping modulo N; o_vld low when no bit is set.
module wb_port_arbiter_rr_pick #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW-1:0] w_cand;

  // Scan farthest-first so the nearest candidate after the pointer wins.
  always_comb begin
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int i = int'(N); i >= 1; i--) begin
      w_cand = IW'((int'(i_ptr) + i) % int'(N));
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Wishbone port arbiter for the TX FIFO write side: grants one port per
// transaction, writes a header word then write-data beats into its channel.
// Build option WB_ARB_FIXED_PRIO_EN selects fixed priority 4,5,6,7,0,1,2,3.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NPORTS = 8,
  parameter int unsigned SELW   = DEF_SELW
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [NPORTS-1:0] cyc_i,
  input  logic [NPORTS-1:0] stb_i,
  input  logic [NPORTS-1:0] we_i,
  input  logic [NPORTS-1:0] eob_i,
  input  logic [NPORTS-1:0] full_i,
  output logic [NPORTS-1:0] grant_o,
  output logic [SELW-1:0]   fifo_sel_o,
  output logic              fifo_we_o,
  output logic              hdr_o,
  output logic [NPORTS-1:0] ack_o
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [NPORTS-1:0] w_elig;
  logic [SELW-1:0]   w_pick_idx;
  logic              w_pick_vld;
  logic              w_cyc;
  logic              w_xfer;
  logic              w_grant_en;
  logic              w_release;

  assign w_elig     = cyc_i & stb_i;
  assign w_cyc      = cyc_i[fifo_sel_o];
  assign w_xfer     = w_cyc & stb_i[fifo_sel_o] & ~full_i[fifo_sel_o];
  assign w_grant_en = (r_state == ST_IDLE) && w_pick_vld;
  assign w_release  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

`ifdef WB_ARB_FIXED_PRIO_EN
  logic [SELW-1:0] w_fp_cand;

  // Lowest-rank eligible port wins; ranks beyond NPORTS are skipped.
  always_comb begin
    w_pick_idx = '0;
    w_pick_vld = 1'b0;
    w_fp_cand  = '0;
    for (int r = int'(FIXED_PRIO_LEN) - 1; r >= 0; r--) begin
      w_fp_cand = SELW'((r + int'(FIXED_PRIO_FIRST)) % int'(FIXED_PRIO_LEN));
      if (int'(w_fp_cand) < int'(NPORTS) && w_elig[w_fp_cand]) begin
        w_pick_idx = w_fp_cand;
        w_pick_vld = 1'b1;
      end
    end
  end
`else
  logic [SELW-1:0] r_rr;

  wb_port_arbiter_rr_pick #(
    .N  (NPORTS),
    .IW (SELW)
  ) u_rr_pick (
    .i_req (w_elig),
    .i_ptr (r_rr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  always_ff @(posedge wb_clk) begin
    if (wb_rst)          r_rr <= SELW'(NPORTS - 1);
    else if (w_grant_en) r_rr <= w_pick_idx;
  end
`endif

  // State register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant and channel select follow the winner; grant drops on release.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      grant_o    <= '0;
      fifo_sel_o <= '0;
    end else if (w_grant_en) begin
      grant_o    <= NPORTS'(1) << w_pick_idx;
      fifo_sel_o <= w_pick_idx;
    end else if (w_release) begin
      grant_o    <= '0;
    end
  end

  // Next-state logic; a dropped cyc aborts the transaction.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_nxt = ST_HDR;
      ST_HDR: begin
        if (!w_cyc)      w_state_nxt = ST_IDLE;
        else if (w_xfer) w_state_nxt = we_i[fifo_sel_o] ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (!w_cyc)                          w_state_nxt = ST_IDLE;
        else if (w_xfer && eob_i[fifo_sel_o]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO strobes; suppressed while reset is asserted.
  always_comb begin
    fifo_we_o = 1'b0;
    hdr_o     = 1'b0;
    ack_o     = '0;
    if (!wb_rst) begin
      unique case (r_state)
        ST_HDR: begin
          fifo_we_o = w_xfer;
          hdr_o     = w_xfer;
        end
        ST_DATA: begin
          fifo_we_o = w_xfer;
          ack_o     = w_xfer ? grant_o : '0;
        end
        default: ;
      endcase
    end
  end

endmodule
